// File: rtl/conv2d_stream_engine.sv
// rtl/conv2d_stream_engine.sv - streaming KxK valid-mode 2-D convolution engine
//
// Purpose: loads (or reuses) a KxK signed kernel, then consumes a W x H raster
// pixel stream and emits one shifted / optional-ReLU / saturated result per
// complete KxK window, in raster order.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   start, reload                    frame start (IDLE only); reload selects kernel load
//   cfg_width/height/shift/relu      frame configuration, latched on accepted start
//   coef_valid, coef_data            kernel beats in raster order, always accepted in LOAD
//   pix_valid, pix_data, pix_ready   pixel stream
//   out_valid, out_data, out_ready   result stream (single output register)
//   busy, done, err                  status: not idle, frame-end pulse, rejected-start pulse
module conv2d_stream_engine #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int K      = 3,
   parameter int MAX_W  = 32,
   parameter int MAX_H  = 255,
   parameter int OUT_W  = 8
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic                             reload,
   input  logic [$clog2(MAX_W+1)-1:0]       cfg_width,
   input  logic [7:0]                       cfg_height,
   input  logic [4:0]                       cfg_shift,
   input  logic                             cfg_relu,
   input  logic                             coef_valid,
   input  logic signed [COEF_W-1:0]         coef_data,
   input  logic                             pix_valid,
   input  logic [DATA_W-1:0]                pix_data,
   output logic                             pix_ready,
   output logic                             out_valid,
   output logic signed [OUT_W-1:0]          out_data,
   input  logic                             out_ready,
   output logic                             busy,
   output logic                             done,
   output logic                             err
);
   localparam int WW    = $clog2(MAX_W + 1);
   localparam int AW    = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int NK    = K * K;
   localparam int KCW   = $clog2(NK);
   localparam int PW    = DATA_W + COEF_W + 1;
   localparam int ACC_W = PW + $clog2(NK);
   localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-(2 ** (OUT_W - 1)));

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN} state_t;

   state_t                     state_q, state_d;
   logic [WW-1:0]              col_q, col_d, width_q, width_d;
   logic [7:0]                 row_q, row_d, height_q, height_d;
   logic [4:0]                 shift_q, shift_d;
   logic                       relu_q, relu_d;
   logic [KCW-1:0]             cnt_q, cnt_d;
   logic                       out_valid_q, out_valid_d;
   logic signed [OUT_W-1:0]    out_data_q, out_data_d;
   logic                       done_q, done_d, err_q, err_d;

   logic signed [COEF_W-1:0]   coef_q [NK];
   // lb_q[0] holds the previous row, lb_q[K-2] the oldest row still needed.
   logic [DATA_W-1:0]          lb_q   [K-1][MAX_W];
   // Previous K-1 columns of the window; column 0 is the oldest.
   logic [DATA_W-1:0]          win_q  [K][K-1];
   logic [DATA_W-1:0]          nwin   [K][K];
   logic [DATA_W-1:0]          col_vec [K];

   logic                       pix_acc, win_done, last_pix, cfg_bad;
   logic [AW-1:0]              col_idx;
   logic signed [PW-1:0]       prod;
   logic signed [ACC_W-1:0]    acc, shifted;
   logic signed [OUT_W-1:0]    res;

   assign pix_ready = (state_q == S_RUN) && (!out_valid_q || out_ready);
   assign pix_acc   = pix_valid && pix_ready;
   assign col_idx   = col_q[AW-1:0];
   assign win_done  = (row_q >= 8'(K - 1)) && (col_q >= WW'(K - 1));
   assign last_pix  = (row_q == height_q - 8'd1) && (col_q == width_q - WW'(1));
   assign cfg_bad   = (32'(cfg_width) < K) || (32'(cfg_width) > MAX_W) ||
                      (32'(cfg_height) < K) || (32'(cfg_height) > MAX_H);

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   // Current column through the line buffers: index i is image row r-K+1+i,
   // so the incoming pixel is the newest row.
   always_comb begin
      for (int i = 0; i < K; i++) col_vec[i] = '0;
      col_vec[K-1] = pix_data;
      for (int i = 0; i < K - 1; i++) col_vec[K-2-i] = lb_q[i][col_idx];
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K - 1; j++) nwin[i][j] = win_q[i][j];
         nwin[i][K-1] = col_vec[i];
      end
   end

   // The window that the accepted pixel completes is evaluated in the same
   // cycle so the result register loads on the handshake edge.
   always_comb begin
      acc  = '0;
      prod = '0;
      for (int i = 0; i < K; i++) begin
         for (int j = 0; j < K; j++) begin
            prod = PW'($signed({1'b0, nwin[i][j]})) * PW'(coef_q[i*K+j]);
            acc  = acc + ACC_W'(prod);
         end
      end
      shifted = acc >>> shift_q;
      if (relu_q && shifted[ACC_W-1]) res = '0;
      else if (shifted > SAT_HI)       res = SAT_HI[OUT_W-1:0];
      else if (shifted < SAT_LO)       res = SAT_LO[OUT_W-1:0];
      else                             res = shifted[OUT_W-1:0];
   end

   always_comb begin
      state_d     = state_q;
      col_d       = col_q;
      row_d       = row_q;
      width_d     = width_q;
      height_d    = height_q;
      shift_d     = shift_q;
      relu_d      = relu_q;
      cnt_d       = cnt_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  err_d = 1'b1;
               end else begin
                  width_d  = cfg_width;
                  height_d = cfg_height;
                  shift_d  = cfg_shift;
                  relu_d   = cfg_relu;
                  col_d    = '0;
                  row_d    = '0;
                  cnt_d    = '0;
                  state_d  = reload ? S_LOAD : S_RUN;
               end
            end
         end
         S_LOAD: begin
            if (coef_valid) begin
               cnt_d = cnt_q + KCW'(1);
               if (cnt_q == KCW'(NK - 1)) state_d = S_RUN;
            end
         end
         S_RUN: begin
            if (pix_acc) begin
               if (win_done) begin
                  out_valid_d = 1'b1;
                  out_data_d  = res;
               end
               if (col_q == width_q - WW'(1)) begin
                  col_d = '0;
                  if (row_q != height_q - 8'd1) row_d = row_q + 8'd1;
               end else begin
                  col_d = col_q + WW'(1);
               end
               // The last pixel always completes a window, so DRAIN waits
               // for exactly that result.
               if (last_pix) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (out_valid_q && out_ready) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         col_q       <= '0;
         row_q       <= '0;
         width_q     <= '0;
         height_q    <= '0;
         shift_q     <= '0;
         relu_q      <= 1'b0;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         col_q       <= col_d;
         row_q       <= row_d;
         width_q     <= width_d;
         height_q    <= height_d;
         shift_q     <= shift_d;
         relu_q      <= relu_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int n = 0; n < NK; n++) coef_q[n] <= '0;
      end else if (state_q == S_LOAD && coef_valid) begin
         coef_q[cnt_q] <= coef_data;
      end
   end

   // Line buffers and window need no reset: nothing is emitted until they
   // have been filled by the current frame.
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         lb_q[0][col_idx] <= pix_data;
         for (int i = 1; i < K - 1; i++) lb_q[i][col_idx] <= lb_q[i-1][col_idx];
         for (int i = 0; i < K; i++)
            for (int j = 0; j < K - 1; j++) win_q[i][j] <= nwin[i][j+1];
      end
   end

endmodule
